direction_input_ctrl: RTL

- Upstream stage of the dot-matrix display. Converts four raw player push-buttons (up/down/left/right) into the 2-bit `dir` code that the display uses to select the arrow glyph and the Pac-Man sprite.
- Per button: synchronises, debounces, and edge-detects. Then resolves simultaneous presses and holds the last accepted direction until a different one is pressed.
- `dir` encoding is fixed: 0 = up (w), 1 = down (s), 2 = left (a), 3 = right (d).

---
 rtl/direction_input_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/direction_input_ctrl.sv
// Player push-button front end: per-button synchroniser, debouncer and rising-edge strobe,
// then fixed-priority resolution into a held 2-bit direction code for the display.
module direction_input_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 20000,
    parameter logic [1:0] RESET_DIR       = 2'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [1:0] dir,
    output logic       dir_change,
    output logic [3:0] btn_stable
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] CODE_UP    = 2'd0;
    localparam logic [1:0] CODE_DOWN  = 2'd1;
    localparam logic [1:0] CODE_LEFT  = 2'd2;
    localparam logic [1:0] CODE_RIGHT = 2'd3;

    logic [3:0]    btn_raw;
    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    stable_q, stable_d;
    logic [3:0]    stable_prev_q;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic [3:0]    press;
    logic          win_vld;
    logic [1:0]    win_code;
    logic [1:0]    dir_q, dir_d;
    logic          dir_change_q, dir_change_d;

    assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

    // Debounce: any cycle of agreement with the stable level restarts the count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign press = stable_q & ~stable_prev_q;

    // Fixed priority up > down > left > right; losing strobes are simply dropped.
    always_comb begin
        win_vld  = 1'b1;
        win_code = CODE_UP;
        if (press[0]) begin
            win_code = CODE_UP;
        end else if (press[1]) begin
            win_code = CODE_DOWN;
        end else if (press[2]) begin
            win_code = CODE_LEFT;
        end else if (press[3]) begin
            win_code = CODE_RIGHT;
        end else begin
            win_vld = 1'b0;
        end
    end

    // A change right after a change is ignored so dir_change can never stay high twice in a row.
    always_comb begin
        dir_d        = dir_q;
        dir_change_d = 1'b0;
        if (win_vld && (win_code != dir_q) && !dir_change_q) begin
            dir_d        = win_code;
            dir_change_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            dir_q        <= RESET_DIR;
            dir_change_q <= 1'b0;
        end else begin
            sync1_q       <= btn_raw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            dir_q        <= dir_d;
            dir_change_q <= dir_change_d;
        end
    end

    assign dir        = dir_q;
    assign dir_change = dir_change_q;
    assign btn_stable = stable_q;

endmodule
